// File: rtl/fetch_stage_pkg.sv
// rv_pkg: types and constants shared by the fetch stage, the IF/ID register and decode.
package rv_pkg;
    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;

    typedef enum logic [2:0] {
        ST_RST,
        ST_REQ,
        ST_WAIT,
        ST_DROP,
        ST_HOLD
    } fetch_state_t;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] inst;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_plus4;
    } if_id_t;
endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// if_id_reg: IF/ID pipeline flop; holds on stall, loads on a delivered instruction,
// otherwise inserts a bubble so decode never sees the same instruction twice.
module if_id_reg #(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
    parameter logic [31:0] NOP_INST   = 32'h0000_0013
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    input  logic           i_hold,
    input  logic           i_load,
    input  rv_pkg::if_id_t i_d,
    output rv_pkg::if_id_t o_q
);
    import rv_pkg::*;

    if_id_t r_q;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_q.valid    <= 1'b0;
            r_q.inst     <= NOP_INST;
            r_q.pc       <= RESET_ADDR;
            r_q.pc_plus4 <= RESET_ADDR + 32'd4;
        end else if (!i_hold) begin
            if (i_load) begin
                r_q <= i_d;
            end else begin
                r_q.valid <= 1'b0;
                r_q.inst  <= NOP_INST;
            end
        end
    end

    assign o_q = r_q;
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC, instruction-memory handshake FSM with skid register, feeding IF/ID.
// Timing note: i_imem_valid -> o_imem_ren/o_imem_addr is a deliberate combinational path (back-to-back issue).
module fetch_stage #(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
    parameter logic [31:0] NOP_INST   = 32'h0000_0013
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_stall_if_id,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    output logic [31:0] o_imem_addr,
    output logic        o_imem_ren,
    input  logic        i_imem_ready,
    input  logic        i_imem_valid,
    input  logic [31:0] i_imem_rdata,
    output logic        o_rst_stall,
    output logic        o_id_valid,
    output logic [31:0] o_id_inst,
    output logic [31:0] o_id_pc,
    output logic [31:0] o_id_pc_plus4
);
    import rv_pkg::*;

    fetch_state_t r_state;
    logic [31:0]  r_pc;
    logic [31:0]  r_skid;
    logic         w_redir;
    logic         w_b2b;
    logic         w_accept;
    logic         w_load;
    logic [31:0]  w_pc4;
    logic [31:0]  w_target;
    if_id_t       w_d;
    if_id_t       w_q;

    // A redirect is only honoured when the branch in ID is itself moving.
    assign w_redir    = i_redirect && !i_stall_if_id;
    assign w_b2b      = r_state == ST_WAIT && i_imem_valid && !i_stall_if_id && !i_redirect;
    assign w_pc4      = r_pc + 32'd4;
    assign w_target   = i_redirect_pc & ~32'd3;
    assign o_imem_ren  = r_state == ST_REQ || w_b2b;
    assign o_imem_addr = w_b2b ? w_pc4 : r_pc;
    assign o_rst_stall = r_state == ST_RST;
    assign w_accept   = o_imem_ren && i_imem_ready;
    assign w_load     = w_b2b || (r_state == ST_HOLD && !i_stall_if_id && !i_redirect);
    assign w_d        = '{valid: 1'b1, inst: w_b2b ? i_imem_rdata : r_skid, pc: r_pc, pc_plus4: w_pc4};

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= ST_RST;
            r_pc    <= RESET_ADDR;
            r_skid  <= '0;
        end else begin
            case (r_state)
                ST_RST: r_state <= ST_REQ;
                ST_REQ: begin
                    if (w_redir) begin
                        r_pc    <= w_target;
                        r_state <= w_accept ? ST_DROP : ST_REQ;
                    end else if (w_accept) begin
                        r_state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (i_imem_valid) begin
                        if (w_redir) begin
                            r_pc    <= w_target;
                            r_state <= ST_REQ;
                        end else if (i_stall_if_id) begin
                            r_skid  <= i_imem_rdata;
                            r_state <= ST_HOLD;
                        end else begin
                            r_pc    <= w_pc4;
                            r_state <= w_accept ? ST_WAIT : ST_REQ;
                        end
                    end else if (w_redir) begin
                        r_pc    <= w_target;
                        r_state <= ST_DROP;
                    end
                end
                ST_DROP: begin
                    if (w_redir) r_pc <= w_target;
                    if (i_imem_valid) r_state <= ST_REQ;
                end
                ST_HOLD: begin
                    if (!i_stall_if_id) begin
                        r_pc    <= i_redirect ? w_target : w_pc4;
                        r_state <= ST_REQ;
                    end
                end
                default: r_state <= ST_RST;
            endcase
        end
    end

    if_id_reg #(
        .RESET_ADDR(RESET_ADDR),
        .NOP_INST  (NOP_INST)
    ) u_if_id (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .i_hold (i_stall_if_id),
        .i_load (w_load),
        .i_d    (w_d),
        .o_q    (w_q)
    );

    assign o_id_valid    = w_q.valid;
    assign o_id_inst     = w_q.inst;
    assign o_id_pc       = w_q.pc;
    assign o_id_pc_plus4 = w_q.pc_plus4;
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed bench with a one-outstanding memory that returns the address as data.
module tb_fetch_stage;
    logic        clk = 0;
    logic        rst_n = 0;
    logic        stall = 0;
    logic        redirect = 0;
    logic [31:0] redirect_pc = 0;
    logic [31:0] imem_addr;
    logic        imem_ren;
    logic        imem_ready = 1;
    logic        imem_valid;
    logic [31:0] imem_rdata;
    logic        rst_stall;
    logic        id_valid;
    logic [31:0] id_inst;
    logic [31:0] id_pc;
    logic [31:0] id_pc_plus4;
    logic        pend;
    logic [31:0] paddr;
    logic        delay = 0;
    int          n_cmp = 0;
    int          n_err = 0;

    fetch_stage dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_stall_if_id(stall),
        .i_redirect   (redirect),
        .i_redirect_pc(redirect_pc),
        .o_imem_addr  (imem_addr),
        .o_imem_ren   (imem_ren),
        .i_imem_ready (imem_ready),
        .i_imem_valid (imem_valid),
        .i_imem_rdata (imem_rdata),
        .o_rst_stall  (rst_stall),
        .o_id_valid   (id_valid),
        .o_id_inst    (id_inst),
        .o_id_pc      (id_pc),
        .o_id_pc_plus4(id_pc_plus4)
    );

    always #5 clk = ~clk;

    // Memory: response one cycle after acceptance, optionally delayed by 'delay'.
    always @(posedge clk) begin
        if (!rst_n) pend <= 1'b0;
        else if (imem_ren && imem_ready) begin
            pend  <= 1'b1;
            paddr <= imem_addr;
        end else if (imem_valid) pend <= 1'b0;
    end
    assign imem_valid = pend && !delay;
    assign imem_rdata = paddr;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_valid"}, {31'd0, id_valid}, 32'd0);
        check({tag, "_inst"}, id_inst, 32'h13);
        check({tag, "_pc"}, id_pc, 32'd0);
        check({tag, "_pc4"}, id_pc_plus4, 32'd4);
        check({tag, "_rst_stall"}, {31'd0, rst_stall}, 32'd1);
        check({tag, "_ren"}, {31'd0, imem_ren}, 32'd0);
        check({tag, "_addr"}, imem_addr, 32'd0);
    endtask

    task automatic check_id(input string tag, input logic [31:0] pc);
        check({tag, "_valid"}, {31'd0, id_valid}, 32'd1);
        check({tag, "_inst"}, id_inst, pc);
        check({tag, "_pc"}, id_pc, pc);
        check({tag, "_pc4"}, id_pc_plus4, pc + 32'd4);
    endtask

    initial begin
        repeat (3) step;
        check_reset("rst");
        rst_n = 1;
        #1 check("c0_rst_stall", {31'd0, rst_stall}, 32'd1);
        step;  // cycle 1
        check("c1_rst_stall", {31'd0, rst_stall}, 32'd0);
        check("c1_ren", {31'd0, imem_ren}, 32'd1);
        check("c1_addr", imem_addr, 32'd0);
        check("c1_valid", {31'd0, id_valid}, 32'd0);
        step;  // cycle 2
        check("c2_addr", imem_addr, 32'd4);
        check("c2_ren", {31'd0, imem_ren}, 32'd1);
        check("c2_valid", {31'd0, id_valid}, 32'd0);
        step;  // cycle 3
        check_id("c3", 32'd0);
        check("c3_addr", imem_addr, 32'd8);
        imem_ready = 0;
        step;  // cycle 4
        check_id("c4", 32'd4);
        check("c4_addr", imem_addr, 32'd8);
        step;
        check("c5_addr", imem_addr, 32'd8);
        check("c5_valid", {31'd0, id_valid}, 32'd0);
        step;
        check("c6_addr", imem_addr, 32'd8);
        check("c6_valid", {31'd0, id_valid}, 32'd0);
        imem_ready = 1;
        step;  // cycle 7
        check("c7_addr", imem_addr, 32'd12);
        check("c7_valid", {31'd0, id_valid}, 32'd0);
        step;  // cycle 8: response for 12, redirect to 0x100 (low bits dropped)
        check_id("c8", 32'd8);
        redirect = 1;
        redirect_pc = 32'h103;
        #1 check("c8_ren_redir", {31'd0, imem_ren}, 32'd0);
        step;  // cycle 9
        redirect = 0;
        check("c9_valid", {31'd0, id_valid}, 32'd0);
        check("c9_addr", imem_addr, 32'h100);
        check("c9_ren", {31'd0, imem_ren}, 32'd1);
        delay = 1;
        step;  // cycle 10: WAIT without response, redirect to 0x200
        check("c10_ren", {31'd0, imem_ren}, 32'd0);
        check("c10_addr", imem_addr, 32'h100);
        redirect = 1;
        redirect_pc = 32'h200;
        step;  // cycle 11: DROP
        redirect = 0;
        check("c11_ren", {31'd0, imem_ren}, 32'd0);
        check("c11_addr", imem_addr, 32'h200);
        check("c11_valid", {31'd0, id_valid}, 32'd0);
        step;
        check("c12_ren", {31'd0, imem_ren}, 32'd0);
        delay = 0;
        step;  // cycle 13: late response discarded
        check("c13_valid", {31'd0, id_valid}, 32'd0);
        check("c13_addr", imem_addr, 32'h200);
        check("c13_ren", {31'd0, imem_ren}, 32'd1);
        step;
        check("c14_addr", imem_addr, 32'h204);
        step;  // cycle 15
        check_id("c15", 32'h200);
        redirect = 1;
        redirect_pc = 32'h10;
        step;  // cycle 16
        redirect = 0;
        check("c16_valid", {31'd0, id_valid}, 32'd0);
        check("c16_addr", imem_addr, 32'h10);
        step;  // cycle 17: response for 16 arrives under stall
        stall = 1;
        #1 check("c17_ren_stall", {31'd0, imem_ren}, 32'd0);
        step;
        check("c18_ren", {31'd0, imem_ren}, 32'd0);
        check("c18_valid", {31'd0, id_valid}, 32'd0);
        step;  // cycle 19
        check("c19_valid", {31'd0, id_valid}, 32'd0);
        stall = 0;
        #1 check("c19_ren", {31'd0, imem_ren}, 32'd0);
        step;  // cycle 20
        check_id("c20", 32'h10);
        check("c20_addr", imem_addr, 32'h14);
        step;
        check("c21_valid", {31'd0, id_valid}, 32'd0);
        check("c21_addr", imem_addr, 32'h18);
        step;  // cycle 22: reset while WAIT
        check_id("c22", 32'h14);
        rst_n = 0;
        step;
        check_reset("mid_rst");
        rst_n = 1;
        step;
        check("r1_addr", imem_addr, 32'd0);
        check("r1_ren", {31'd0, imem_ren}, 32'd1);
        step;
        check("r2_addr", imem_addr, 32'd4);
        step;  // restart delivers PC 0, then wrap test
        check_id("r3", 32'd0);
        redirect = 1;
        redirect_pc = 32'hFFFF_FFFC;
        step;
        redirect = 0;
        check("w1_valid", {31'd0, id_valid}, 32'd0);
        check("w1_addr", imem_addr, 32'hFFFF_FFFC);
        step;
        check("w2_addr_wrap", imem_addr, 32'd0);
        check("w2_ren", {31'd0, imem_ren}, 32'd1);
        step;
        check_id("w3", 32'hFFFF_FFFC);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
